// File: rtl/decode_pkg.sv
// Shared types for the decode stage: control word, immediate formats, opcodes,
// and the opcode decoder / immediate generator helpers.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU ops are {funct7[5], funct3}; with branch=1 they are {1, funct3} compare codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    imm_fmt_e fmt;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     uses_rd;
  } dec_t;

  localparam ctrl_t CTRL_ILLEGAL = '{illegal: 1'b1, default: '0};

  function automatic dec_t decode_op(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic       funct7b5);
    dec_t d;
    d = '0;
    case (opcode)
      OPC_LUI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = ALU_PASSB;
        d.fmt            = IMM_U;
        d.uses_rd        = 1'b1;
      end
      OPC_AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.fmt            = IMM_U;
        d.uses_rd        = 1'b1;
      end
      OPC_JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.fmt            = IMM_J;
        d.uses_rd        = 1'b1;
      end
      OPC_JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.fmt            = IMM_I;
        d.uses_rs1       = 1'b1;
        d.uses_rd        = 1'b1;
      end
      OPC_BRANCH: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = {1'b1, funct3};
        d.fmt         = IMM_B;
        d.uses_rs1    = 1'b1;
        d.uses_rs2    = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.fmt            = IMM_I;
        d.uses_rs1       = 1'b1;
        d.uses_rd        = 1'b1;
      end
      OPC_STORE: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.fmt            = IMM_S;
        d.uses_rs1       = 1'b1;
        d.uses_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        // only shift-right immediates carry the arithmetic/logical select in funct7
        d.ctrl.alu_op    = {(funct3 == 3'b101) && funct7b5, funct3};
        d.fmt            = IMM_I;
        d.uses_rs1       = 1'b1;
        d.uses_rd        = 1'b1;
      end
      OPC_OP: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = {funct7b5, funct3};
        d.uses_rs1       = 1'b1;
        d.uses_rs2       = 1'b1;
        d.uses_rd        = 1'b1;
      end
      default: d.ctrl.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_pipe_hazard_unit.sv
// Load-use hazard detection: stalls a fetch instruction that reads the
// destination of a load still sitting in EX.
module decode_pipe_hazard_unit #(
  parameter int REG_ID_W = 5
) (
  input  logic                if_valid,
  input  logic                id_valid,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic [REG_ID_W-1:0] rs1,
  input  logic [REG_ID_W-1:0] rs2,
  input  logic                uses_rs1,
  input  logic                uses_rs2,
  output logic                stall
);

  assign stall = if_valid && id_valid && ex_mem_read && (ex_rd != '0) &&
                 ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/decode_pipe_regfile.sv
// Architectural register file: two combinational read ports with writeback
// bypass, one write port; x0 is hard-wired to zero.
module decode_pipe_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_ID_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REG_ID_W-1:0] waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [REG_ID_W-1:0] raddr1,
  input  logic [REG_ID_W-1:0] raddr2,
  output logic [XLEN-1:0]     rdata1,
  output logic [XLEN-1:0]     rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 == '0)                    rdata1 = '0;
    else if (wr_en && (waddr == raddr1)) rdata1 = wdata;
    else                                 rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 == '0)                    rdata2 = '0;
    else if (wr_en && (waddr == raddr2)) rdata2 = wdata;
    else                                 rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage with ID/EX register, load-use stall and branch flush.
// Optional DECODE_PERF_CNT_EN adds saturating stall/flush counters.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_ID_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         instruction,
  input  logic [XLEN-1:0]     pc,
  input  logic                wb_reg_write,
  input  logic [REG_ID_W-1:0] wb_id,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_data1,
  output logic [XLEN-1:0]     id_data2,
  output logic [XLEN-1:0]     id_imm,
  output logic [REG_ID_W-1:0] id_rs1,
  output logic [REG_ID_W-1:0] id_rs2,
  output logic [REG_ID_W-1:0] id_rd,
  output logic [XLEN-1:0]     id_pc,
  output logic [XLEN-1:0]     id_pc_branch,
  output ctrl_t               id_control
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  logic [REG_ID_W-1:0] rs1, rs2, rd;
  dec_t                dec;
  logic [31:0]         imm32;
  logic [XLEN-1:0]     imm;
  logic [XLEN-1:0]     rdata1, rdata2;
  logic                stall, advance, accept, bad_idx;

  assign rs1   = instruction[15 +: REG_ID_W];
  assign rs2   = instruction[20 +: REG_ID_W];
  assign rd    = instruction[7 +: REG_ID_W];
  assign dec   = decode_op(instruction[6:0], instruction[14:12], instruction[30]);
  assign imm32 = imm_gen(instruction[31:7], dec.fmt);
  assign imm   = XLEN'($signed(imm32));

  // RV32E: any referenced register index with bit 4 set does not exist
  assign bad_idx = (NUM_REGS < 32) &&
                   ((dec.uses_rs1 && instruction[19]) ||
                    (dec.uses_rs2 && instruction[24]) ||
                    (dec.uses_rd  && instruction[11]));

  decode_pipe_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .REG_ID_W (REG_ID_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_reg_write),
    .waddr  (wb_id),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  decode_pipe_hazard_unit #(
    .REG_ID_W (REG_ID_W)
  ) u_hazard (
    .if_valid    (if_valid),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .uses_rs1    (dec.uses_rs1),
    .uses_rs2    (dec.uses_rs2),
    .stall       (stall)
  );

  assign advance  = !id_valid || ex_ready;
  assign if_ready = !stall && advance;
  assign accept   = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_data1     <= '0;
      id_data2     <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_pc        <= '0;
      id_pc_branch <= '0;
      id_control   <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      id_control <= '0;
    end else if (advance) begin
      if (accept && !bad_idx) begin
        id_valid     <= 1'b1;
        id_data1     <= rdata1;
        id_data2     <= rdata2;
        id_imm       <= imm;
        id_rs1       <= rs1;
        id_rs2       <= rs2;
        id_rd        <= rd;
        id_pc        <= pc;
        id_pc_branch <= pc + imm;
        id_control   <= dec.ctrl;
      end else begin
        // stall bubble, drained slot, or nonexistent register index
        id_valid   <= 1'b0;
        id_control <= (accept && bad_idx) ? CTRL_ILLEGAL : '0;
      end
    end
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Parametrised decode stage for the in-order RISC-V core. It sits between fetch and execute and contains the following:
- register file with write-through bypass;
- immediate generator;
- opcode-to-control decode;
- load-use hazard detector;
- registered ID/EX pipeline register with valid/ready handshake and branch flush.

It generalises the previous decode stage in register width, register count and pipeline control.

Parameters:
- XLEN, 32, data/register/PC width (32 or 64).
- NUM_REGS, 32, architectural registers (16 for RV32E, 32 for RV32I); x0 is hard-wired zero.
- REG_ID_W, $clog2(NUM_REGS), register index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_ready  out  1  decode accepts this cycle (combinational).
- instruction  in  32  instruction word.
- pc  in  XLEN  PC of the instruction.
- wb_reg_write  in  1  writeback enable.
- wb_id  in  REG_ID_W  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  REG_ID_W  destination of the instruction in EX.
- flush  in  1  branch taken in EX; kill decode contents.
- ex_ready  in  1  execute accepts the ID/EX register.
- id_valid  out  1  ID/EX register holds a valid instruction.
- id_data1, id_data2  out  XLEN  operand values.
- id_imm  out  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  out  REG_ID_W  register indices.
- id_pc  out  XLEN  PC.
- id_pc_branch  out  XLEN  pc + imm (imm already in byte units for B/J).
- id_control  out  ctrl_t  decoded control word.

Behaviour:
Reset:
- All id_* outputs are 0 and id_valid=0 on the cycle after rst is sampled high.
- Register file contents are cleared to 0.
- rst overrides flush, stall and handshake.

Handshake:
- Transfer from fetch occurs when if_valid && if_ready.
- Transfer to execute occurs when id_valid && ex_ready.
- if_ready = !stall && (!id_valid || ex_ready).
- Latency is exactly one cycle from accept to id_valid.

Load-use stall:
- stall = if_valid && id_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
- uses_rs1/uses_rs2 come from the opcode. LUI, AUIPC and JAL use neither; I-type, load and JALR use rs1 only.
- On stall with ex_ready=1: load a bubble (id_valid=0, id_control=0) and leave the fetch instruction pending.
- The stall lasts one cycle per load.

Flush:
- When flush=1, next cycle id_valid=0 and the incoming instruction is dropped, regardless of if_valid.
- flush has priority over stall and accept.

Hold:
- When id_valid && !ex_ready && !flush, all id_* outputs hold.

Register file:
- Write at posedge when wb_reg_write && wb_id!=0.
- Reads are combinational.
- Bypass: if wb_reg_write && wb_id!=0 && wb_id==rs, operand = wb_data.
- Index 0 always reads 0.
- When NUM_REGS=16, an index with bit 4 set raises illegal in ctrl_t and the instruction is treated as a bubble.

Immediates:
- I/S/B/U/J formats, sign-extended to XLEN.
- B and J immediates include the implicit zero LSB; no further shift.
- id_pc_branch wraps modulo 2^XLEN.

Illegal opcodes:
- Produce ctrl_t with illegal=1 and all write/memory enables 0.
- id_valid is still asserted, so execute can trap.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt, 32 bits each, cleared by rst.
  - Incremented once per stall cycle and once per flush cycle respectively.
  - Saturate at all-ones.
- Undefined: the ports and the logic are absent.

Decomposition:
Package decode_pkg holds:
- ctrl_t packed struct with fields reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op[3:0], illegal;
- opcode localparams;
- imm_fmt_e enum.

One natural sub-module is hazard_unit: stall equation, uses_rs1/uses_rs2 inputs, purely combinational. The register file is a second instance of the existing register file generalised by XLEN/NUM_REGS.

Test Plan:
- Reset: rst high 2 cycles with if_valid=1 → id_valid=0, all id_* outputs 0, x1..x31 read 0.
- ADDI x1,x0,5 (0x00500093) at pc=0x100 → next cycle id_imm=5, id_rd=1, id_pc=0x100, control.reg_write=1, alu_src=1.
- Bypass: wb writes x2=0xDEADBEEF in the same cycle ADD x3,x2,x2 is accepted → id_data1=id_data2=0xDEADBEEF; writes to x0 read back 0.
- Load-use: ex_mem_read=1, ex_rd=5, incoming ADD x6,x5,x1 → if_ready=0 for one cycle, bubble issued; next cycle accepted with if_ready=1.
- Flush and backpressure:
  - flush=1 with if_valid=1 → id_valid=0 next cycle.
  - ex_ready=0 for 3 cycles → id_* outputs stable and if_ready=0.
- Branch: BEQ with imm=-8 at pc=0x20 → id_pc_branch=0x18. JAL with imm=+2048 at pc=0xFFFFFFFC (XLEN=32) → id_pc_branch=0x7FC (wrap).
